// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient loader.
// Holds the sequencer states, widths and the tap-count clamp.
package fir_pkg;

  localparam int P_DATA_W    = 16;
  localparam int P_ADDR_W    = 6;
  localparam int P_MAX_COEFF = 16;

  localparam logic [P_ADDR_W-1:0] C_MAX_N =
    P_ADDR_W'(P_MAX_COEFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABORT,
    S_PREP,
    S_WRITE,
    S_WEND,
    S_RUN,
    S_SWEEP
  } state_t;

  typedef struct packed {
    logic flag;
    logic csn;
    logic wrn;
  } ram_cmd_t;

  localparam ram_cmd_t CMD_IDLE  = 3'b011;
  localparam ram_cmd_t CMD_ABORT = 3'b110;
  localparam ram_cmd_t CMD_WRITE = 3'b100;
  localparam ram_cmd_t CMD_READ  = 3'b001;

  // Controller command lines implied by the state being entered.
  function automatic ram_cmd_t cmd_of(input state_t s);
    ram_cmd_t c;
    case (s)
      S_ABORT:         c = CMD_ABORT;
      S_PREP, S_WRITE: c = CMD_WRITE;
      S_SWEEP:         c = CMD_READ;
      default:         c = CMD_IDLE;
    endcase
    return c;
  endfunction

  function automatic logic [P_ADDR_W-1:0] clamp_n(
    input logic [P_ADDR_W-1:0] n
  );
    return (n > C_MAX_N) ? C_MAX_N : n;
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Coefficient load and per-sample read sweep sequencer that drives
// the transposed-FIR controller RAM command port.
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       iLoadStart,
  input  logic [P_ADDR_W-1:0]        iNumOfCoeff,
  input  logic                       iCoeffValid,
  input  logic signed [P_DATA_W-1:0] iCoeffData,
  output logic                       oCoeffReady,
  input  logic                       iSampleValid,
  output logic                       oCoeffiUpdateFlag,
  output logic                       oCsnRam,
  output logic                       oWrnRam,
  output logic [P_ADDR_W-1:0]        oAddrRam,
  output logic signed [P_DATA_W-1:0] oWrDtRam,
  output logic [P_ADDR_W-1:0]        oNumOfCoeff,
  output logic                       oLoadDone,
  output logic                       oLoadErr,
  output logic                       oSweepActive,
  output logic                       oOverrun
);

  state_t                     r_state;
  ram_cmd_t                   r_cmd;
  logic [P_ADDR_W-1:0]        r_cnt;
  logic [P_ADDR_W-1:0]        r_n;
  logic [P_ADDR_W-1:0]        r_addr;
  logic signed [P_DATA_W-1:0] r_data;
  logic                       r_arm;
  logic                       r_pend;
  logic                       r_ovr;
  logic                       r_ready;
  logic                       r_done;
  logic                       r_err;
  logic                       r_sweep;

  state_t                     w_state;
  logic [P_ADDR_W-1:0]        w_cnt;
  logic [P_ADDR_W-1:0]        w_n;
  logic [P_ADDR_W-1:0]        w_addr;
  logic signed [P_DATA_W-1:0] w_data;
  logic                       w_arm;
  logic                       w_pend;
  logic                       w_ovr;
  logic                       w_done;
  logic                       w_err;
  logic                       w_start_ok;
  logic                       w_start_bad;
  logic                       w_last;
  logic                       w_beat;

  assign w_start_ok  = iLoadStart && (iNumOfCoeff != '0);
  assign w_start_bad = iLoadStart && (iNumOfCoeff == '0);
  assign w_last      = (r_cnt == r_n - 1'b1);
  assign w_beat      = r_ready && iCoeffValid;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_n     = r_n;
    w_addr  = r_addr;
    w_data  = r_data;
    w_arm   = r_arm;
    w_pend  = r_pend;
    w_ovr   = r_ovr;
    w_done  = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_err = w_start_bad;
        if (w_start_ok) begin
          w_state = S_ABORT;
          w_n     = clamp_n(iNumOfCoeff);
        end
      end
      S_ABORT: begin
        w_state = S_PREP;
        w_addr  = '0;
        w_cnt   = '0;
      end
      S_PREP: w_state = S_WRITE;
      S_WRITE: begin
        if (w_beat) begin
          w_addr = r_cnt;
          w_data = iCoeffData;
          if (w_last) begin
            w_state = S_WEND;
            w_done  = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      S_WEND: begin
        w_state = S_RUN;
        w_data  = '0;
      end
      S_RUN: begin
        w_err = w_start_bad;
        if (w_start_ok) begin
          w_state = S_ABORT;
          w_n     = clamp_n(iNumOfCoeff);
          w_pend  = 1'b0;
          w_ovr   = 1'b0;
        end else if (iSampleValid || r_pend) begin
          w_state = S_SWEEP;
          w_cnt   = '0;
          w_addr  = '0;
          w_arm   = 1'b1;
          w_pend  = r_pend && iSampleValid;
        end
      end
      S_SWEEP: begin
        w_err = w_start_bad;
        if (w_start_ok) begin
          w_state = S_ABORT;
          w_n     = clamp_n(iNumOfCoeff);
          w_pend  = 1'b0;
          w_ovr   = 1'b0;
          w_arm   = 1'b0;
        end else begin
          if (iSampleValid) begin
            if (r_pend) w_ovr  = 1'b1;
            else        w_pend = 1'b1;
          end
          // First sweep cycle only lets the controller catch up.
          if (r_arm) begin
            w_arm = 1'b0;
          end else if (w_last) begin
            w_state = S_RUN;
          end else begin
            w_cnt  = r_cnt + 1'b1;
            w_addr = r_cnt + 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= S_IDLE;
      r_cmd   <= CMD_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_arm   <= 1'b0;
      r_pend  <= 1'b0;
      r_ovr   <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sweep <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cmd   <= cmd_of(w_state);
      r_cnt   <= w_cnt;
      r_n     <= w_n;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_arm   <= w_arm;
      r_pend  <= w_pend;
      r_ovr   <= w_ovr;
      r_ready <= (w_state == S_WRITE);
      r_done  <= w_done;
      r_err   <= w_err;
      r_sweep <= (w_state == S_SWEEP);
    end
  end

  assign oCoeffiUpdateFlag = r_cmd.flag;
  assign oCsnRam           = r_cmd.csn;
  assign oWrnRam           = r_cmd.wrn;
  assign oAddrRam          = r_addr;
  assign oWrDtRam          = r_data;
  assign oNumOfCoeff       = r_n;
  assign oCoeffReady       = r_ready;
  assign oLoadDone         = r_done;
  assign oLoadErr          = r_err;
  assign oSweepActive      = r_sweep;
  assign oOverrun          = r_ovr;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a per-cycle
// expectation queue filled as stimulus is applied.
module tb_fir_coeff_loader;

  logic               clk = 1'b0;
  logic               rsn = 1'b0;
  logic               ld  = 1'b0;
  logic [5:0]         nin = '0;
  logic               cv  = 1'b0;
  logic signed [15:0] cd  = '0;
  logic               sv  = 1'b0;

  logic               rdy, flag, csn, wrn;
  logic [5:0]         addr, nout;
  logic signed [15:0] wdt;
  logic               done, err, swp, ovr;

  fir_coeff_loader u_dut (
    .iClk_12M          (clk),
    .iRsn              (rsn),
    .iLoadStart        (ld),
    .iNumOfCoeff       (nin),
    .iCoeffValid       (cv),
    .iCoeffData        (cd),
    .oCoeffReady       (rdy),
    .iSampleValid      (sv),
    .oCoeffiUpdateFlag (flag),
    .oCsnRam           (csn),
    .oWrnRam           (wrn),
    .oAddrRam          (addr),
    .oWrDtRam          (wdt),
    .oNumOfCoeff       (nout),
    .oLoadDone         (done),
    .oLoadErr          (err),
    .oSweepActive      (swp),
    .oOverrun          (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [28:0] v;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] bt[16];
  logic [28:0] w_obs;

  assign w_obs = {flag, csn, wrn, rdy, done, err, swp, addr, wdt};

  // Bus layout: flag csn wrn ready done err sweep addr data
  function automatic logic [28:0] ev(
    input logic f, c, w, r, d, e, s,
    input logic [5:0]  a,
    input logic [15:0] dt
  );
    return {f, c, w, r, d, e, s, a, dt};
  endfunction

  task automatic chk(input string tag, input logic [28:0] obs,
                     input logic [28:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [28:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL sb_empty: got no expectation, required one");
    end else begin
      e = q.pop_front();
      chk(e.tag, w_obs, e.v);
    end
  endtask

  task automatic drain();
    while (q.size() > 0) tick();
  endtask

  task automatic push_sweep(input int n);
    push("arm", ev(0, 0, 1, 0, 0, 0, 1, 6'd0, 16'd0));
    for (int a = 0; a < n; a++)
      push("rd", ev(0, 0, 1, 0, 0, 0, 1, 6'(a), 16'd0));
    push("gap", ev(0, 1, 1, 0, 0, 0, 0, 6'(n - 1), 16'd0));
  endtask

  task automatic do_load(input int nreq, input int neff,
                         input int st_at, input int st_len,
                         input logic [5:0] a0, input logic smp);
    ld  = 1'b1;
    nin = 6'(nreq);
    sv  = smp;
    push("abort", ev(1, 1, 0, 0, 0, 0, 0, a0, 16'd0));
    tick();
    ld = 1'b0;
    sv = 1'b0;
    chk("n_latch", {23'd0, nout}, {23'd0, 6'(neff)});
    chk("ovr_clr", {28'd0, ovr}, 29'd0);
    push("prep", ev(1, 0, 0, 0, 0, 0, 0, 6'd0, 16'd0));
    tick();
    push("write0", ev(1, 0, 0, 1, 0, 0, 0, 6'd0, 16'd0));
    tick();
    for (int k = 0; k < neff; k++) begin
      cv = 1'b1;
      cd = bt[k];
      if (k == neff - 1)
        push("wend", ev(0, 1, 1, 0, 1, 0, 0, 6'(k), bt[k]));
      else
        push("write", ev(1, 0, 0, 1, 0, 0, 0, 6'(k), bt[k]));
      tick();
      if (k == st_at) begin
        cv = 1'b0;
        cd = 16'hDEAD;
        repeat (st_len) begin
          push("stall", ev(1, 0, 0, 1, 0, 0, 0, 6'(k), bt[k]));
          tick();
        end
      end
    end
    cv = 1'b0;
    push("run", ev(0, 1, 1, 0, 0, 0, 0, 6'(neff - 1), 16'd0));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bt[0] = 16'h0010;
    bt[1] = 16'h0020;
    bt[2] = 16'hFFF0;
    bt[3] = 16'h7FFF;

    @(posedge clk);
    #1;
    chk("rst_bus", w_obs, ev(0, 1, 1, 0, 0, 0, 0, 6'd0, 16'd0));
    chk("rst_n", {23'd0, nout}, 29'd0);
    chk("rst_ovr", {28'd0, ovr}, 29'd0);
    @(negedge clk);
    rsn = 1'b1;
    push("idle", ev(0, 1, 1, 0, 0, 0, 0, 6'd0, 16'd0));
    tick();

    do_load(4, 4, -1, 0, 6'd0, 1'b0);

    sv = 1'b1;
    push_sweep(4);
    tick();
    sv = 1'b0;
    drain();

    sv = 1'b1;
    push_sweep(4);
    tick();
    sv = 1'b0;
    tick();
    sv = 1'b1;
    push_sweep(4);
    tick();
    sv = 1'b0;
    drain();
    chk("no_ovr", {28'd0, ovr}, 29'd0);

    sv = 1'b1;
    push_sweep(4);
    tick();
    push_sweep(4);
    tick();
    tick();
    sv = 1'b0;
    chk("ovr_set", {28'd0, ovr}, 29'd1);
    drain();
    chk("ovr_sticky", {28'd0, ovr}, 29'd1);

    ld  = 1'b1;
    nin = 6'd0;
    push("load_err", ev(0, 1, 1, 0, 0, 1, 0, 6'd3, 16'd0));
    tick();
    ld = 1'b0;
    chk("err_keep_n", {23'd0, nout}, 29'd4);
    chk("err_keep_ovr", {28'd0, ovr}, 29'd1);
    push("err_pulse", ev(0, 1, 1, 0, 0, 0, 0, 6'd3, 16'd0));
    tick();

    do_load(4, 4, 1, 3, 6'd3, 1'b0);

    sv = 1'b1;
    push("m_arm", ev(0, 0, 1, 0, 0, 0, 1, 6'd0, 16'd0));
    tick();
    push("m_rd0", ev(0, 0, 1, 0, 0, 0, 1, 6'd0, 16'd0));
    tick();
    sv = 1'b0;
    push("m_rd1", ev(0, 0, 1, 0, 0, 0, 1, 6'd1, 16'd0));
    tick();
    do_load(4, 4, -1, 0, 6'd1, 1'b1);
    push("no_pend", ev(0, 1, 1, 0, 0, 0, 0, 6'd3, 16'd0));
    tick();
    push("no_pend", ev(0, 1, 1, 0, 0, 0, 0, 6'd3, 16'd0));
    tick();

    for (int i = 0; i < 16; i++) bt[i] = 16'($urandom);
    do_load(40, 16, -1, 0, 6'd3, 1'b0);
    sv = 1'b1;
    push_sweep(16);
    tick();
    sv = 1'b0;
    drain();

    ld  = 1'b1;
    nin = 6'd4;
    push("r_abort", ev(1, 1, 0, 0, 0, 0, 0, 6'd15, 16'd0));
    tick();
    ld = 1'b0;
    push("r_prep", ev(1, 0, 0, 0, 0, 0, 0, 6'd0, 16'd0));
    tick();
    push("r_write0", ev(1, 0, 0, 1, 0, 0, 0, 6'd0, 16'd0));
    tick();
    cv = 1'b1;
    cd = bt[0];
    push("r_write", ev(1, 0, 0, 1, 0, 0, 0, 6'd0, bt[0]));
    tick();
    #2;
    rsn = 1'b0;
    #1;
    chk("async_rst", w_obs, ev(0, 1, 1, 0, 0, 0, 0, 6'd0, 16'd0));
    chk("async_rst_n", {23'd0, nout}, 29'd0);
    cv = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
    push("post_rst", ev(0, 1, 1, 0, 0, 0, 0, 6'd0, 16'd0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
